phy_cfg_sequencer: RTL and testbench
====================================

Name: phy_cfg_sequencer

Overview:
- Upstream command source for the MDIO management-frame engine.
- After a start pulse it issues a fixed PHY bring-up sequence over a req/ack handshake: soft reset, poll for reset self-clear, write the control word, then poll link status.
- Reports busy, done, link_up and timeout. It generates no MDC/MDIO itself; the frame engine serialises each request.

Parameters:
- PHY_ADDR, 5'b10000, PHY address placed on every request.
- CTRL_WORD, 16'h1301, value written to register 0 after reset completes.
- POLL_MAX, 1000, maximum read attempts per poll phase before timeout (10-bit counter).
- POLL_GAP, 5000, clk cycles idle between successive poll reads (16-bit counter, must be >=1).

Ports:
- clk  input  1  system clock, also the MDC source domain.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins the sequence from IDLE or DONE/ERR.
- mdio_req  output  1  request valid to the frame engine.
- mdio_op  output  1  0 = write, 1 = read (same encoding as the engine's sw input).
- mdio_phy_ad  output  5  PHY address, always PHY_ADDR.
- mdio_reg_ad  output  5  register address.
- mdio_wdata  output  16  write data; 16'h0000 for reads.
- mdio_ack  input  1  one-cycle pulse from the engine at frame completion.
- mdio_rdata  input  16  read data; valid in the mdio_ack cycle of a read.
- busy  output  1  high from the cycle after start until DONE/ERR.
- done  output  1  level; sequence completed with link up.
- link_up  output  1  level; BMSR bit 2 seen set.
- timeout_err  output  1  level; a poll phase exhausted POLL_MAX.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, mdio_wdata 0, mdio_reg_ad 0.
- Handshake:
  - mdio_req rises with op/reg_ad/wdata already stable.
  - Fields stay stable while req is high.
  - req drops the cycle after mdio_ack is sampled high.
  - Next req no earlier than one cycle later (minimum one low cycle between requests).
  - An ack while req is low is ignored.
- States and transitions:
  - IDLE: start -> RST_WR; busy=1 next cycle.
  - RST_WR: write reg 0 = 16'h8000; on ack -> RST_POLL, poll_cnt=0.
  - RST_POLL: read reg 0. On ack:
    - rdata[15]==0 -> CFG_WR.
    - Else if poll_cnt==POLL_MAX-1 -> ERR.
    - Else poll_cnt+1, -> RST_GAP.
  - RST_GAP: count POLL_GAP cycles -> RST_POLL.
  - CFG_WR: write reg 0 = CTRL_WORD; on ack -> LNK_POLL, poll_cnt=0.
  - LNK_POLL: read reg 1. On ack:
    - rdata[2]==1 -> link_up=1, DONE.
    - Else timeout check as in RST_POLL -> ERR or LNK_GAP.
  - LNK_GAP: count POLL_GAP cycles -> LNK_POLL.
  - DONE: busy=0, done=1. start -> clear done/link_up/timeout_err, RST_WR.
  - ERR: busy=0, timeout_err=1. start -> clear flags, RST_WR.
- Timing and boundaries:
  - start while busy is ignored.
  - Gap counter reloads on entry to each GAP state; exactly POLL_GAP idle cycles between ack and next req.
  - POLL_MAX=1 means a single read attempt.
  - Reset mid-transaction: req drops immediately (async) and the engine is expected to be reset by the same rst_n.
  - start and ack in the same cycle: ack is processed, start is ignored.

Optional Feature:
- Macro PHY_ID_CHECK_EN.
- Defined:
  - From IDLE, start -> ID_HI: read reg 2, then ID_LO: read reg 3.
  - Adds output phy_id [31:0] = {reg2, reg3}, reset 0.
  - Adds output no_phy, reset 0.
  - If both reads return 16'hFFFF (pulled-up bus, no PHY): no_phy=1 and -> ERR with timeout_err=0.
  - Otherwise -> RST_WR.
- Undefined: no ID states; phy_id and no_phy ports absent; start goes straight to RST_WR.

Test Plan:
- Nominal: reg0 reads 16'h0000 first poll, reg1 reads 16'h0004 first poll -> exactly 4 requests: (W,0,8000), (R,0), (W,0,1301), (R,1); done=1, link_up=1, busy=0.
- Reset slow to clear: reg0 returns 16'h8000 three times then 16'h0000 -> 4 reg0 reads, each req exactly POLL_GAP cycles after previous ack, then CFG_WR.
- Link timeout: POLL_MAX=4, reg1 always 16'h0000 -> 4 reg1 reads, then timeout_err=1, done=0, busy=0; a further start restarts the sequence with flags cleared.
- Handshake: engine delays ack 40 cycles -> req held, fields constant for all 40 cycles; req low the cycle after ack; start pulsed mid-sequence is ignored.
- Async reset asserted while req high in LNK_POLL -> all outputs 0 immediately; after release, IDLE until start.
- With PHY_ID_CHECK_EN, reg2/reg3 both 16'hFFFF -> no_phy=1, ERR, no writes issued. With reg2=16'h0022, reg3=16'h1622 -> phy_id=32'h00221622 and the sequence continues to RST_WR.

Source files
------------

// File: rtl/phy_cfg_sequencer_if.sv
// Request/acknowledge bundle between phy_cfg_sequencer (master) and the
// MDIO frame engine (slave). The engine serialises each request into a frame
// and pulses mdio_ack for one cycle when that frame completes.
interface phy_cfg_sequencer_if;
    logic        mdio_req;
    logic        mdio_op;       // 0 = write, 1 = read
    logic [4:0]  mdio_phy_ad;
    logic [4:0]  mdio_reg_ad;
    logic [15:0] mdio_wdata;
    logic        mdio_ack;
    logic [15:0] mdio_rdata;

    modport master (
        output mdio_req, mdio_op, mdio_phy_ad, mdio_reg_ad, mdio_wdata,
        input  mdio_ack, mdio_rdata
    );

    modport slave (
        input  mdio_req, mdio_op, mdio_phy_ad, mdio_reg_ad, mdio_wdata,
        output mdio_ack, mdio_rdata
    );
endinterface

// File: rtl/phy_cfg_sequencer.sv
// PHY bring-up command sequencer: soft reset, poll reset self-clear, write the
// control word, poll link status. Requests go to the MDIO frame engine over a
// req/ack handshake; all outputs are registered.
// Optional build macro PHY_ID_CHECK_EN: reads PHY ID registers 2/3 first and
// aborts with no_phy when both read back as all-ones (no PHY on the bus).
module phy_cfg_sequencer #(
    parameter logic [4:0]  PHY_ADDR  = 5'b10000,
    parameter logic [15:0] CTRL_WORD = 16'h1301,
    parameter int unsigned POLL_MAX  = 1000,
    parameter int unsigned POLL_GAP  = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    phy_cfg_sequencer_if.master mdio,
    output logic busy,
    output logic done,
    output logic link_up,
    output logic timeout_err
`ifdef PHY_ID_CHECK_EN
    ,
    output logic [31:0] phy_id,
    output logic        no_phy
`endif
);

    localparam logic [9:0]  POLL_LAST = 10'(POLL_MAX - 1);
    localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_WR,
        S_RST_POLL,
        S_RST_GAP,
        S_CFG_WR,
        S_LNK_POLL,
        S_LNK_GAP,
        S_DONE,
        S_ERR
`ifdef PHY_ID_CHECK_EN
        ,
        S_ID_HI,
        S_ID_LO
`endif
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic        op_q;
    logic [4:0]  phy_ad_q;
    logic [4:0]  reg_ad_q;
    logic [15:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        link_up_q;
    logic        timeout_q;
    logic [9:0]  poll_cnt_q;
    logic [15:0] gap_cnt_q;
`ifdef PHY_ID_CHECK_EN
    logic [15:0] id_hi_q;
    logic [31:0] phy_id_q;
    logic        no_phy_q;
`endif

    // Frame completion is only meaningful while a request is outstanding.
    logic ack_d;
    always_comb begin
        ack_d = req_q & mdio.mdio_ack;
    end

    // Sequencer FSM. Request states raise req (with its fields) on the first
    // cycle req is low there, so one idle cycle always separates requests.
    // A GAP state raises the next poll read itself on expiry, which makes the
    // idle time between ack and the next req exactly POLL_GAP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            op_q       <= 1'b0;
            phy_ad_q   <= '0;
            reg_ad_q   <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            link_up_q  <= 1'b0;
            timeout_q  <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
`ifdef PHY_ID_CHECK_EN
            id_hi_q    <= '0;
            phy_id_q   <= '0;
            no_phy_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
`ifdef PHY_ID_CHECK_EN
                        state_q <= S_ID_HI;
`else
                        state_q <= S_RST_WR;
`endif
                    end
                end

`ifdef PHY_ID_CHECK_EN
                S_ID_HI: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd2;
                        wdata_q  <= '0;
                    end else if (ack_d) begin
                        req_q   <= 1'b0;
                        id_hi_q <= mdio.mdio_rdata;
                        state_q <= S_ID_LO;
                    end
                end

                S_ID_LO: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd3;
                        wdata_q  <= '0;
                    end else if (ack_d) begin
                        req_q    <= 1'b0;
                        phy_id_q <= {id_hi_q, mdio.mdio_rdata};
                        if (id_hi_q == 16'hFFFF && mdio.mdio_rdata == 16'hFFFF) begin
                            no_phy_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_ERR;
                        end else begin
                            state_q  <= S_RST_WR;
                        end
                    end
                end
`endif

                S_RST_WR: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b0;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd0;
                        wdata_q  <= 16'h8000;
                    end else if (ack_d) begin
                        req_q      <= 1'b0;
                        poll_cnt_q <= '0;
                        state_q    <= S_RST_POLL;
                    end
                end

                S_RST_POLL: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd0;
                        wdata_q  <= '0;
                    end else if (ack_d) begin
                        req_q <= 1'b0;
                        if (!mdio.mdio_rdata[15]) begin
                            state_q <= S_CFG_WR;
                        end else if (poll_cnt_q == POLL_LAST) begin
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= S_ERR;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 10'd1;
                            gap_cnt_q  <= GAP_LAST;
                            state_q    <= S_RST_GAP;
                        end
                    end
                end

                S_RST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd0;
                        wdata_q  <= '0;
                        state_q  <= S_RST_POLL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end

                S_CFG_WR: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b0;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd0;
                        wdata_q  <= CTRL_WORD;
                    end else if (ack_d) begin
                        req_q      <= 1'b0;
                        poll_cnt_q <= '0;
                        state_q    <= S_LNK_POLL;
                    end
                end

                S_LNK_POLL: begin
                    if (!req_q) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd1;
                        wdata_q  <= '0;
                    end else if (ack_d) begin
                        req_q <= 1'b0;
                        if (mdio.mdio_rdata[2]) begin
                            link_up_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_DONE;
                        end else if (poll_cnt_q == POLL_LAST) begin
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= S_ERR;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 10'd1;
                            gap_cnt_q  <= GAP_LAST;
                            state_q    <= S_LNK_GAP;
                        end
                    end
                end

                S_LNK_GAP: begin
                    if (gap_cnt_q == '0) begin
                        req_q    <= 1'b1;
                        op_q     <= 1'b1;
                        phy_ad_q <= PHY_ADDR;
                        reg_ad_q <= 5'd1;
                        wdata_q  <= '0;
                        state_q  <= S_LNK_POLL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 16'd1;
                    end
                end

                S_DONE, S_ERR: begin
                    if (start) begin
                        done_q    <= 1'b0;
                        link_up_q <= 1'b0;
                        timeout_q <= 1'b0;
`ifdef PHY_ID_CHECK_EN
                        no_phy_q  <= 1'b0;
`endif
                        busy_q    <= 1'b1;
                        state_q   <= S_RST_WR;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mdio.mdio_req    = req_q;
    assign mdio.mdio_op     = op_q;
    assign mdio.mdio_phy_ad = phy_ad_q;
    assign mdio.mdio_reg_ad = reg_ad_q;
    assign mdio.mdio_wdata  = wdata_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign link_up          = link_up_q;
    assign timeout_err      = timeout_q;
`ifdef PHY_ID_CHECK_EN
    assign phy_id           = phy_id_q;
    assign no_phy           = no_phy_q;
`endif

endmodule

// File: tb/tb_phy_cfg_sequencer.sv
// Bench for phy_cfg_sequencer: a behavioural MDIO engine answers requests with
// randomised latency and per-scenario register contents; the expected request
// list and final flags come from a transaction-level model of the bring-up
// sequence. Build with +define+PHY_ID_CHECK_EN to cover the ID probe.
module tb_phy_cfg_sequencer;

    localparam int          PM = 4;
    localparam int unsigned PG = 6;
    localparam logic [4:0]  PA = 5'b10000;
    localparam logic [15:0] CW = 16'h1301;

    logic clk = 1'b0;
    logic rst_n;
    logic start = 1'b0;
    logic busy, done, link_up, timeout_err;
`ifdef PHY_ID_CHECK_EN
    logic [31:0] phy_id;
    logic        no_phy;
`endif

    phy_cfg_sequencer_if mdio_bus();

    phy_cfg_sequencer #(
        .PHY_ADDR (PA),
        .CTRL_WORD(CW),
        .POLL_MAX (PM),
        .POLL_GAP (PG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mdio       (mdio_bus),
        .busy       (busy),
        .done       (done),
        .link_up    (link_up),
        .timeout_err(timeout_err)
`ifdef PHY_ID_CHECK_EN
        ,
        .phy_id     (phy_id),
        .no_phy     (no_phy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [4:0]  pa;
        int unsigned gap;     // model: PG for a repeated poll, 0 = any >= 1
        bit          stable;
    } txn_t;

    txn_t        obs[$];
    txn_t        expq[$];
    logic [15:0] rsp0[PM];
    logic [15:0] rsp1[PM];
    logic [15:0] id_hi_v = 16'h0022;
    logic [15:0] id_lo_v = 16'h1622;
    int          fixed_delay = -1;
    int unsigned i0, i1, low_cnt, dly;
    bit          in_req, acked;
    txn_t        cur;
    bit          exp_done, exp_link, exp_to, exp_nophy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural frame engine: acks after a random or fixed latency and
    // records each request with its preceding idle time and field stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdio_bus.mdio_ack   = 1'b0;
            mdio_bus.mdio_rdata = '0;
            in_req  = 1'b0;
            acked   = 1'b0;
            low_cnt = 0;
        end else if (acked) begin
            check("req_drop_after_ack", mdio_bus.mdio_req, 1'b0);
            mdio_bus.mdio_ack = 1'b0;
            acked   = 1'b0;
            in_req  = 1'b0;
            obs.push_back(cur);
            low_cnt = 1;
        end else if (mdio_bus.mdio_req) begin
            if (!in_req) begin
                in_req     = 1'b1;
                cur.op     = mdio_bus.mdio_op;
                cur.ra     = mdio_bus.mdio_reg_ad;
                cur.wd     = mdio_bus.mdio_wdata;
                cur.pa     = mdio_bus.mdio_phy_ad;
                cur.gap    = low_cnt;
                cur.stable = 1'b1;
                dly = (fixed_delay >= 0) ? unsigned'(fixed_delay) : $urandom_range(0, 5);
            end else if (cur.op !== mdio_bus.mdio_op || cur.ra !== mdio_bus.mdio_reg_ad ||
                         cur.wd !== mdio_bus.mdio_wdata || cur.pa !== mdio_bus.mdio_phy_ad) begin
                cur.stable = 1'b0;
            end
            if (dly == 0) begin
                mdio_bus.mdio_ack = 1'b1;
                if (!cur.op) begin
                    mdio_bus.mdio_rdata = 16'($urandom);
                end else begin
                    case (cur.ra)
                        5'd0: begin
                            mdio_bus.mdio_rdata = (i0 < PM) ? rsp0[i0] : 16'h8000;
                            i0++;
                        end
                        5'd1: begin
                            mdio_bus.mdio_rdata = (i1 < PM) ? rsp1[i1] : 16'h0000;
                            i1++;
                        end
                        5'd2:    mdio_bus.mdio_rdata = id_hi_v;
                        5'd3:    mdio_bus.mdio_rdata = id_lo_v;
                        default: mdio_bus.mdio_rdata = 16'($urandom);
                    endcase
                end
                acked = 1'b1;
            end else begin
                dly--;
            end
        end else begin
            if (in_req) cur.stable = 1'b0;
            low_cnt++;
        end
    end

    function automatic void add_exp(input logic op, input logic [4:0] ra,
                                    input logic [15:0] wd, input int unsigned gap);
        txn_t t;
        t.op = op; t.ra = ra; t.wd = wd; t.pa = PA; t.gap = gap; t.stable = 1'b1;
        expq.push_back(t);
    endfunction

    // Reference: the request list and final flags implied by the register
    // contents the engine will return.
    task automatic build_expected(input bit from_idle);
        bit cleared = 1'b0;
        bit linked  = 1'b0;
        expq.delete();
        exp_done = 0; exp_link = 0; exp_to = 0; exp_nophy = 0;
`ifdef PHY_ID_CHECK_EN
        if (from_idle) begin
            add_exp(1'b1, 5'd2, 16'h0000, 0);
            add_exp(1'b1, 5'd3, 16'h0000, 0);
            if (id_hi_v == 16'hFFFF && id_lo_v == 16'hFFFF) begin
                exp_nophy = 1;
                return;
            end
        end
`endif
        add_exp(1'b0, 5'd0, 16'h8000, 0);
        for (int k = 0; k < PM; k++) begin
            add_exp(1'b1, 5'd0, 16'h0000, (k > 0) ? PG : 0);
            if (!rsp0[k][15]) begin
                cleared = 1'b1;
                break;
            end
        end
        if (!cleared) begin
            exp_to = 1;
            return;
        end
        add_exp(1'b0, 5'd0, CW, 0);
        for (int k = 0; k < PM; k++) begin
            add_exp(1'b1, 5'd1, 16'h0000, (k > 0) ? PG : 0);
            if (rsp1[k][2]) begin
                linked = 1'b1;
                break;
            end
        end
        if (linked) begin
            exp_done = 1;
            exp_link = 1;
        end else begin
            exp_to = 1;
        end
    endtask

    task automatic set_rsp(input int nr, input int nl);
        for (int k = 0; k < PM; k++) begin
            rsp0[k] = (k < nr) ? (16'($urandom) | 16'h8000) : (16'($urandom) & 16'h7FFF);
            rsp1[k] = (k < nl) ? (16'($urandom) & 16'hFFFB) : (16'($urandom) | 16'h0004);
        end
    endtask

    task automatic run_seq(input bit from_idle, input int fdelay, input bit glitch);
        bit fin = 1'b0;
        bit got = 1'b0;
        int n;
        build_expected(from_idle);
        obs.delete();
        i0 = 0; i1 = 0;
        fixed_delay = fdelay;
        if (from_idle) check("idle_flags_clear", {busy, done, link_up, timeout_err}, 4'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("flags_clear_after_start", {done, link_up, timeout_err}, 3'b0);
        if (glitch) begin
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk); #1;
                if (mdio_bus.mdio_ack) got = 1'b1;
            end
            check("ack_seen_for_start_collision", got, 1'b1);
            if (got) begin
                start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
        end else begin
            repeat (3) @(negedge clk);
            if (busy) start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (!busy) fin = 1'b1;
        end
        check("sequence_completes", fin, 1'b1);
        repeat (2) @(negedge clk);
        check("txn_count", obs.size(), expq.size());
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("txn%0d_op_reg_wdata", k), {obs[k].op, obs[k].ra, obs[k].wd},
                  {expq[k].op, expq[k].ra, expq[k].wd});
            check($sformatf("txn%0d_phy_ad", k), obs[k].pa, PA);
            check($sformatf("txn%0d_stable", k), obs[k].stable, 1'b1);
            if (k > 0) begin
                if (expq[k].gap > 0) check($sformatf("txn%0d_poll_gap", k), obs[k].gap, PG);
                else                 check($sformatf("txn%0d_min_gap", k), obs[k].gap >= 1, 1'b1);
            end
        end
        check("final_busy", busy, 1'b0);
        check("final_done", done, exp_done);
        check("final_link_up", link_up, exp_link);
        check("final_timeout_err", timeout_err, exp_to);
`ifdef PHY_ID_CHECK_EN
        check("final_no_phy", no_phy, exp_nophy);
`endif
    endtask

    task automatic reset_mid_link();
        bit found = 1'b0;
        set_rsp(0, PM);
        obs.delete();
        i0 = 0; i1 = 0;
        fixed_delay = 10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (mdio_bus.mdio_req && mdio_bus.mdio_op && mdio_bus.mdio_reg_ad == 5'd1) found = 1'b1;
        end
        check("reached_link_poll", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {mdio_bus.mdio_req, mdio_bus.mdio_op, mdio_bus.mdio_phy_ad, mdio_bus.mdio_reg_ad,
               mdio_bus.mdio_wdata, busy, done, link_up, timeout_err}, '0);
`ifdef PHY_ID_CHECK_EN
        check("async_reset_id_outputs", {phy_id, no_phy}, '0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {busy, mdio_bus.mdio_req}, 2'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs",
              {mdio_bus.mdio_req, mdio_bus.mdio_op, mdio_bus.mdio_phy_ad, mdio_bus.mdio_reg_ad,
               mdio_bus.mdio_wdata, busy, done, link_up, timeout_err}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // From IDLE: ID probe sees an empty bus (ID build) / nominal run
        set_rsp(0, 0);
        id_hi_v = 16'hFFFF; id_lo_v = 16'hFFFF;
        run_seq(1'b1, -1, 1'b0);
`ifdef PHY_ID_CHECK_EN
        check("phy_id_empty_bus", phy_id, 32'hFFFF_FFFF);
`endif

        // Nominal: first polls succeed
        set_rsp(0, 0);
        rsp0[0] = 16'h0000; rsp1[0] = 16'h0004;
        run_seq(1'b0, -1, 1'b0);

        // Reset slow to clear
        set_rsp(3, 0);
        rsp0[0] = 16'h8000; rsp0[1] = 16'h8000; rsp0[2] = 16'h8000; rsp0[3] = 16'h0000;
        run_seq(1'b0, -1, 1'b0);

        // Link never comes up
        set_rsp(0, PM);
        for (int k = 0; k < PM; k++) rsp1[k] = 16'h0000;
        run_seq(1'b0, -1, 1'b0);

        // Slow engine, start colliding with an ack
        set_rsp(0, 0);
        run_seq(1'b0, 40, 1'b1);

        // Reset never self-clears
        set_rsp(PM, 0);
        run_seq(1'b0, -1, 1'b0);

        reset_mid_link();

        // From IDLE with a real PHY ID
        id_hi_v = 16'h0022; id_lo_v = 16'h1622;
        set_rsp($urandom_range(0, PM - 1), $urandom_range(0, PM - 1));
        run_seq(1'b1, -1, 1'b0);
`ifdef PHY_ID_CHECK_EN
        check("phy_id_present", phy_id, 32'h0022_1622);
`endif

        for (int r = 0; r < 6; r++) begin
            set_rsp($urandom_range(0, PM), $urandom_range(0, PM));
            run_seq(1'b0, -1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
